// File: rtl/byte_unstrip_pkg.sv
// Shared constants, group packing and FSM encodings for the 4-lane byte un-striper.
package byte_unstrip_pkg;

    localparam int DEF_BITS  = 8;
    localparam int NUM_LANES = 4;
    localparam int DEF_DEPTH = 2;
    localparam int GROUP_W   = NUM_LANES * DEF_BITS + NUM_LANES;

    // Lane 0 sits in the low bits so it is the first byte serialised.
    typedef struct packed {
        logic [NUM_LANES-1:0] dk;
        logic [DEF_BITS-1:0]  lane3;
        logic [DEF_BITS-1:0]  lane2;
        logic [DEF_BITS-1:0]  lane1;
        logic [DEF_BITS-1:0]  lane0;
    } group_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/byte_unstrip_if.sv
// Parallel 4-lane group input plus serialised byte output of the un-striper.
interface byte_unstrip_if #(
    parameter int BITS = 8
);
    logic            VALID_IN;
    logic [BITS-1:0] LANE0;
    logic [BITS-1:0] LANE1;
    logic [BITS-1:0] LANE2;
    logic [BITS-1:0] LANE3;
    logic            DK_0;
    logic            DK_1;
    logic            DK_2;
    logic            DK_3;
    logic [BITS-1:0] D;
    logic            DK;
    logic            VALID_OUT;
    logic            OVERFLOW;

    modport slave (
        input  VALID_IN, LANE0, LANE1, LANE2, LANE3, DK_0, DK_1, DK_2, DK_3,
        output D, DK, VALID_OUT, OVERFLOW
    );

    modport master (
        output VALID_IN, LANE0, LANE1, LANE2, LANE3, DK_0, DK_1, DK_2, DK_3,
        input  D, DK, VALID_OUT, OVERFLOW
    );
endinterface

// File: rtl/byte_unstrip_group_fifo.sv
// Synchronous group FIFO, head visible combinationally; a push into a full FIFO
// succeeds only when a pop happens on the same edge, otherwise it is ignored.
module group_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/byte_unstrip.sv
// Re-serialises 4-lane byte groups into one byte/cycle in lane order 0..3; lane0 one edge after capture.
// No backpressure: a group arriving while the FIFO is full and not popping is dropped and OVERFLOW sticks.
module byte_unstrip
    import byte_unstrip_pkg::*;
#(
    parameter int BITS  = DEF_BITS,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic CLK,
    input  logic RESET_L,
    byte_unstrip_if.slave bus
);
    localparam int GW = NUM_LANES * BITS + NUM_LANES;

    state_t          state_q;
    state_t          state_d;
    logic [1:0]      cnt_q;
    logic [1:0]      cnt_d;
    logic [GW-1:0]   hold_q;
    logic [GW-1:0]   hold_d;
    logic [BITS-1:0] d_q;
    logic [BITS-1:0] d_d;
    logic            dk_q;
    logic            dk_d;
    logic            vld_q;
    logic            vld_d;
    logic            ovf_q;
    logic            start;

    logic [GW-1:0]   in_group;
    logic [GW-1:0]   head;
    logic            full;
    logic            empty;
    logic            pop;

    assign in_group = {bus.DK_3, bus.DK_2, bus.DK_1, bus.DK_0,
                       bus.LANE3, bus.LANE2, bus.LANE1, bus.LANE0};

    group_fifo #(
        .WIDTH (GW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .rst_n     (RESET_L),
        .push      (bus.VALID_IN),
        .push_data (in_group),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        pop     = 1'b0;
        start   = 1'b0;
        d_d     = '0;
        dk_d    = 1'b0;
        vld_d   = 1'b0;

        case (state_q)
            IDLE: begin
                start = !empty;
            end
            SEND: begin
                if (cnt_q == 2'd0) begin
                    // Group boundary: chain straight into the next group, no bubble.
                    start = !empty;
                    if (empty) state_d = IDLE;
                end else begin
                    d_d   = hold_q[int'(cnt_q) * BITS +: BITS];
                    dk_d  = hold_q[NUM_LANES * BITS + int'(cnt_q)];
                    vld_d = 1'b1;
                    cnt_d = 2'(cnt_q + 2'd1);
                    if (cnt_q == 2'd3 && empty) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (start) begin
            pop     = 1'b1;
            hold_d  = head;
            d_d     = head[BITS-1:0];
            dk_d    = head[NUM_LANES * BITS];
            vld_d   = 1'b1;
            cnt_d   = 2'd1;
            state_d = SEND;
        end
    end

    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
            d_q     <= '0;
            dk_q    <= 1'b0;
            vld_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            d_q     <= d_d;
            dk_q    <= dk_d;
            vld_q   <= vld_d;
            if (bus.VALID_IN && full && !pop) ovf_q <= 1'b1;
        end
    end

    assign bus.D         = d_q;
    assign bus.DK        = dk_q;
    assign bus.VALID_OUT = vld_q;
    assign bus.OVERFLOW  = ovf_q;

endmodule

// File: tb/tb_byte_unstrip.sv
// Directed bench for byte_unstrip: expected bytes queued at issue, checked by a negedge monitor.
module tb_byte_unstrip;

    logic CLK;
    logic RESET_L;
    int   tests;
    int   fails;

    logic [8:0]  sb[$];
    logic [63:0] vtr;
    logic [63:0] otr;

    byte_unstrip_if #(.BITS(8)) bus ();

    byte_unstrip dut (
        .CLK     (CLK),
        .RESET_L (RESET_L),
        .bus     (bus.slave)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (RESET_L) begin
            if (bus.VALID_OUT) begin
                if (sb.size() == 0) begin
                    chk("unexpected_byte", {55'd0, bus.DK, bus.D}, 64'hFFFF);
                end else begin
                    chk("out_byte", {55'd0, bus.DK, bus.D}, {55'd0, sb.pop_front()});
                end
            end else begin
                chk("idle_d_zero", {55'd0, bus.DK, bus.D}, 64'd0);
            end
        end
    end

    task automatic cyc(input logic v, input logic [7:0] l0, input logic [7:0] l1,
                       input logic [7:0] l2, input logic [7:0] l3,
                       input logic [3:0] dk, input bit enq);
        bus.VALID_IN = v;
        bus.LANE0 = l0; bus.LANE1 = l1; bus.LANE2 = l2; bus.LANE3 = l3;
        bus.DK_0 = dk[0]; bus.DK_1 = dk[1]; bus.DK_2 = dk[2]; bus.DK_3 = dk[3];
        if (v && enq) begin
            sb.push_back({dk[0], l0});
            sb.push_back({dk[1], l1});
            sb.push_back({dk[2], l2});
            sb.push_back({dk[3], l3});
        end
        @(negedge CLK);
        vtr = {vtr[62:0], bus.VALID_OUT};
        otr = {otr[62:0], bus.OVERFLOW};
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0, 1'b0);
    endtask

    task automatic do_reset();
        #1;
        RESET_L = 1'b0;
        #1;
        chk("rst_d", {55'd0, bus.DK, bus.D}, 64'd0);
        chk("rst_valid", {63'd0, bus.VALID_OUT}, 64'd0);
        chk("rst_ovf", {63'd0, bus.OVERFLOW}, 64'd0);
        sb.delete();
        @(negedge CLK);
        RESET_L = 1'b1;
        vtr = '0;
        otr = '0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        vtr = '0;
        otr = '0;
        RESET_L = 1'b0;
        bus.VALID_IN = 1'b0;
        bus.LANE0 = '0; bus.LANE1 = '0; bus.LANE2 = '0; bus.LANE3 = '0;
        bus.DK_0 = 1'b0; bus.DK_1 = 1'b0; bus.DK_2 = 1'b0; bus.DK_3 = 1'b0;
        #2;
        chk("por_d", {55'd0, bus.DK, bus.D}, 64'd0);
        chk("por_valid", {63'd0, bus.VALID_OUT}, 64'd0);
        chk("por_ovf", {63'd0, bus.OVERFLOW}, 64'd0);
        @(negedge CLK);
        RESET_L = 1'b1;
        idle(2);

        // Single group with a K byte on lane 0
        vtr = '0;
        cyc(1'b1, 8'hBC, 8'h01, 8'h02, 8'h03, 4'b0001, 1'b1);
        idle(5);
        chk("single_valid_trace", {58'd0, vtr[5:0]}, 64'b011110);
        chk("single_sb_empty", 64'(sb.size()), 64'd0);

        // Reset while lane1 of a group is on D
        cyc(1'b1, 8'h55, 8'h66, 8'h77, 8'h88, 4'b0000, 1'b1);
        idle(2);
        chk("mid_pre_d", {56'd0, bus.D}, 64'h66);
        chk("mid_pre_valid", {63'd0, bus.VALID_OUT}, 64'd1);
        do_reset();
        cyc(1'b1, 8'h11, 8'h22, 8'h33, 8'h44, 4'b0000, 1'b1);
        idle(6);
        chk("mid_post_valid_trace", {57'd0, vtr[6:0]}, 64'b0111100);
        chk("mid_sb_empty", 64'(sb.size()), 64'd0);

        // Sustained stream: one group every 4 cycles
        vtr = '0;
        cyc(1'b1, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 4'b0000, 1'b1);
        idle(3);
        cyc(1'b1, 8'hB0, 8'hB1, 8'hB2, 8'hB3, 4'b1000, 1'b1);
        idle(3);
        cyc(1'b1, 8'hC0, 8'hC1, 8'hC2, 8'hC3, 4'b0110, 1'b1);
        idle(5);
        chk("stream_valid_trace", {50'd0, vtr[13:0]}, 64'b01111111111110);
        chk("stream_ovf", {63'd0, bus.OVERFLOW}, 64'd0);
        chk("stream_sb_empty", 64'(sb.size()), 64'd0);

        // Burst of 3 back-to-back groups fits exactly
        vtr = '0;
        otr = '0;
        cyc(1'b1, 8'h10, 8'h11, 8'h12, 8'h13, 4'b0001, 1'b1);
        cyc(1'b1, 8'h20, 8'h21, 8'h22, 8'h23, 4'b0010, 1'b1);
        cyc(1'b1, 8'h30, 8'h31, 8'h32, 8'h33, 4'b0100, 1'b1);
        idle(11);
        chk("burst3_valid_trace", {50'd0, vtr[13:0]}, 64'b01111111111110);
        chk("burst3_ovf_trace", {50'd0, otr[13:0]}, 64'd0);
        chk("burst3_sb_empty", 64'(sb.size()), 64'd0);

        // Burst of 4: the 4th group is dropped and OVERFLOW sticks
        vtr = '0;
        otr = '0;
        cyc(1'b1, 8'h40, 8'h41, 8'h42, 8'h43, 4'b0000, 1'b1);
        cyc(1'b1, 8'h50, 8'h51, 8'h52, 8'h53, 4'b1111, 1'b1);
        cyc(1'b1, 8'h60, 8'h61, 8'h62, 8'h63, 4'b0000, 1'b1);
        cyc(1'b1, 8'h70, 8'h71, 8'h72, 8'h73, 4'b0000, 1'b0);
        idle(10);
        chk("burst4_valid_trace", {50'd0, vtr[13:0]}, 64'b01111111111110);
        chk("burst4_ovf_trace", {50'd0, otr[13:0]}, 64'b00011111111111);
        chk("burst4_sb_empty", 64'(sb.size()), 64'd0);
        idle(3);
        chk("burst4_ovf_held", {63'd0, bus.OVERFLOW}, 64'd1);
        do_reset();
        idle(2);
        chk("ovf_after_reset", {63'd0, bus.OVERFLOW}, 64'd0);

        // Idle gap: group, 7 idle cycles, group
        vtr = '0;
        cyc(1'b1, 8'hD0, 8'hD1, 8'hD2, 8'hD3, 4'b0000, 1'b1);
        idle(7);
        cyc(1'b1, 8'hE0, 8'hE1, 8'hE2, 8'hE3, 4'b0000, 1'b1);
        idle(5);
        chk("gap_valid_trace", {50'd0, vtr[13:0]}, 64'b01111000011110);
        chk("gap_sb_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
